sprite_blitter: RTL and testbench

Parametrised multi-sprite successor to the single-target sprite engine. It holds a table of NUM_SPRITES sprite descriptors: position, ROM id, enable, and horizontal/vertical flip. On START it draws every enabled slot in ascending slot order into the frame buffer. It fetches pixels from the sprite ROM through a pipeline of configurable latency, suppresses the transparency key, and clips pixels that fall outside the playfield. It sits between the frame controller FSM, the sprite ROM and the frame buffer write port.

---
 rtl/sprite_pkg.sv | 28 ++
 rtl/sprite_blitter_table.sv | 31 +++
 rtl/sprite_blitter.sv | 230 +++++++++++++++++++++++
 tb/tb_sprite_blitter.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// sprite_pkg: shared types and defaults for the sprite blitter.
// Descriptor fields are sized by the package defaults.
package sprite_pkg;

  localparam int COORD_W_DEFAULT = 9;
  localparam int ID_W_DEFAULT = 2;
  localparam int FB_W_DEFAULT = 320;
  localparam int FB_H_DEFAULT = 240;
  localparam logic [7:0] KEY_DEFAULT = 8'hE3;

  typedef struct packed {
    logic [COORD_W_DEFAULT-1:0] x;
    logic [COORD_W_DEFAULT-1:0] y;
    logic [ID_W_DEFAULT-1:0] id;
    logic en;
    logic flipx;
    logic flipy;
  } sprite_desc_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN,
    S_DRAW,
    S_DRAIN,
    S_FINISH
  } blit_state_t;

endpackage

// File: rtl/sprite_blitter_table.sv
// sprite_table: descriptor register file, one write port,
// one combinational read port, cleared by reset.
module sprite_table
  import sprite_pkg::*;
#(
  parameter int N = 4,
  parameter int SW = $clog2(N)
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         we_i,
  input  logic [SW-1:0] wslot_i,
  input  sprite_desc_t wdata_i,
  input  logic [SW-1:0] rslot_i,
  output sprite_desc_t rdata_o
);

  sprite_desc_t tbl_q [N];

  // Slot write; reset disables every slot.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < N; i++) tbl_q[i] <= '0;
    end else if (we_i) begin
      tbl_q[wslot_i] <= wdata_i;
    end
  end

  assign rdata_o = tbl_q[rslot_i];

endmodule

// File: rtl/sprite_blitter.sv
// sprite_blitter: draws every enabled sprite slot into the frame
// buffer with transparency keying and playfield clipping.
module sprite_blitter
  import sprite_pkg::*;
#(
  parameter int NUM_SPRITES = 4,
  parameter int SPR_SIZE = 32,
  parameter int COORD_W = COORD_W_DEFAULT,
  parameter int FB_W = FB_W_DEFAULT,
  parameter int FB_H = FB_H_DEFAULT,
  parameter int ID_W = ID_W_DEFAULT,
  parameter int ROM_LAT = 1,
  parameter logic [7:0] KEY = KEY_DEFAULT,
  localparam int SW = $clog2(NUM_SPRITES),
  localparam int AW = $clog2(SPR_SIZE)
) (
  input  logic               CLOCK_50,
  input  logic               RESET_N,
  input  logic               START,
  input  logic               CFG_WE,
  input  logic [SW-1:0]      CFG_SLOT,
  input  logic [COORD_W-1:0] CFG_X,
  input  logic [COORD_W-1:0] CFG_Y,
  input  logic [ID_W-1:0]    CFG_ID,
  input  logic               CFG_EN,
  input  logic               CFG_FLIPX,
  input  logic               CFG_FLIPY,
  input  logic [7:0]         PIXEL_DIN,
  output logic               RE,
  output logic [ID_W-1:0]    SPRITE_ID,
  output logic [AW-1:0]      SPRITE_X,
  output logic [AW-1:0]      SPRITE_Y,
  output logic               WE,
  output logic [7:0]         PIXEL_DOUT,
  output logic [COORD_W-1:0] PIXEL_X,
  output logic [COORD_W-1:0] PIXEL_Y,
  output logic               BUSY,
  output logic               SPR_DONE
);

  localparam int DW = $clog2(ROM_LAT + 2);
  localparam int SUM_W = COORD_W + 1;
  localparam logic [SW-1:0] LAST_SLOT = SW'(NUM_SPRITES - 1);

  typedef struct packed {
    logic v;
    logic clip;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } ent_t;

  blit_state_t state_q;
  logic [SW-1:0] slot_q;
  logic [AW-1:0] col_q, row_q;
  logic [AW-1:0] col_d, row_d;
  logic [DW-1:0] drain_q;
  logic last_px;

  logic re_q, busy_q, done_q, we_q;
  logic [ID_W-1:0] id_q;
  logic [AW-1:0] sx_q, sy_q;
  logic [7:0] dout_q;
  logic [COORD_W-1:0] px_q, py_q;

  sprite_desc_t cfg_desc, desc;
  logic [SUM_W-1:0] sum_x, sum_y;
  ent_t ent_d, head;
  ent_t pipe_q [ROM_LAT];
  logic wr;

  // Pack the configuration bus into a descriptor.
  always_comb begin
    cfg_desc = '0;
    cfg_desc.x = COORD_W_DEFAULT'(CFG_X);
    cfg_desc.y = COORD_W_DEFAULT'(CFG_Y);
    cfg_desc.id = ID_W_DEFAULT'(CFG_ID);
    cfg_desc.en = CFG_EN;
    cfg_desc.flipx = CFG_FLIPX;
    cfg_desc.flipy = CFG_FLIPY;
  end

  sprite_table #(
    .N (NUM_SPRITES)
  ) u_table (
    .clk_i   (CLOCK_50),
    .rst_ni  (RESET_N),
    .we_i    (CFG_WE && !busy_q),
    .wslot_i (CFG_SLOT),
    .wdata_i (cfg_desc),
    .rslot_i (slot_q),
    .rdata_o (desc)
  );

  // Next raster position inside the sprite.
  always_comb begin
    col_d = col_q + 1'b1;
    row_d = (col_q == '1) ? row_q + 1'b1 : row_q;
    last_px = (col_q == '1) && (row_q == '1);
  end

  // Frame coordinate of the pixel being fetched; one extra bit
  // so sums past the playfield clip instead of wrapping.
  always_comb begin
    sum_x = SUM_W'(COORD_W'(desc.x)) + SUM_W'(col_q);
    sum_y = SUM_W'(COORD_W'(desc.y)) + SUM_W'(row_q);
    ent_d.v = re_q;
    ent_d.clip = (sum_x >= SUM_W'(FB_W)) ||
                 (sum_y >= SUM_W'(FB_H));
    ent_d.x = sum_x[COORD_W-1:0];
    ent_d.y = sum_y[COORD_W-1:0];
  end

  // Scan slots, walk each enabled sprite, then drain the pipe.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= S_IDLE;
      slot_q <= '0;
      col_q <= '0;
      row_q <= '0;
      drain_q <= '0;
      re_q <= 1'b0;
      id_q <= '0;
      sx_q <= '0;
      sy_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (START) begin
            state_q <= S_SCAN;
            slot_q <= '0;
            busy_q <= 1'b1;
          end
        end
        S_SCAN: begin
          if (desc.en) begin
            state_q <= S_DRAW;
            col_q <= '0;
            row_q <= '0;
            re_q <= 1'b1;
            id_q <= ID_W'(desc.id);
            sx_q <= desc.flipx ? '1 : '0;
            sy_q <= desc.flipy ? '1 : '0;
          end else if (slot_q == LAST_SLOT) begin
            state_q <= S_DRAIN;
            drain_q <= '0;
          end else begin
            slot_q <= slot_q + 1'b1;
          end
        end
        S_DRAW: begin
          if (last_px) begin
            re_q <= 1'b0;
            if (slot_q == LAST_SLOT) begin
              state_q <= S_DRAIN;
              drain_q <= '0;
            end else begin
              state_q <= S_SCAN;
              slot_q <= slot_q + 1'b1;
            end
          end else begin
            col_q <= col_d;
            row_q <= row_d;
            sx_q <= desc.flipx ? ~col_d : col_d;
            sy_q <= desc.flipy ? ~row_d : row_d;
          end
        end
        S_DRAIN: begin
          if (drain_q == DW'(ROM_LAT)) begin
            state_q <= S_FINISH;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end else begin
            drain_q <= drain_q + 1'b1;
          end
        end
        S_FINISH: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          re_q <= 1'b0;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  // Coordinates and clip flag ride alongside the ROM latency.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < ROM_LAT; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= ent_d;
      for (int i = 1; i < ROM_LAT; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign head = pipe_q[ROM_LAT-1];
  assign wr = head.v && !head.clip && (PIXEL_DIN != KEY);

  // Frame buffer write port; idle cycles drive zeros.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      we_q <= 1'b0;
      dout_q <= '0;
      px_q <= '0;
      py_q <= '0;
    end else begin
      we_q <= wr;
      dout_q <= wr ? PIXEL_DIN : '0;
      px_q <= wr ? head.x : '0;
      py_q <= wr ? head.y : '0;
    end
  end

  assign RE = re_q;
  assign SPRITE_ID = id_q;
  assign SPRITE_X = sx_q;
  assign SPRITE_Y = sy_q;
  assign WE = we_q;
  assign PIXEL_DOUT = dout_q;
  assign PIXEL_X = px_q;
  assign PIXEL_Y = py_q;
  assign BUSY = busy_q;
  assign SPR_DONE = done_q;

endmodule

// File: tb/tb_sprite_blitter.sv
// tb_sprite_blitter: random and directed draws checked against
// a per-pixel reference of the expected frame buffer writes.
module tb_sprite_blitter;

  localparam int N = 4;
  localparam int S = 32;
  localparam int LAT = 1;
  localparam logic [7:0] KEYV = 8'hE3;

  logic CLOCK_50 = 1'b0;
  logic RESET_N = 1'b0;
  logic START = 1'b0;
  logic CFG_WE = 1'b0;
  logic [1:0] CFG_SLOT = '0;
  logic [8:0] CFG_X = '0;
  logic [8:0] CFG_Y = '0;
  logic [1:0] CFG_ID = '0;
  logic CFG_EN = 1'b0;
  logic CFG_FLIPX = 1'b0;
  logic CFG_FLIPY = 1'b0;
  logic [7:0] PIXEL_DIN = '0;
  logic RE, WE, BUSY, SPR_DONE;
  logic [1:0] SPRITE_ID;
  logic [4:0] SPRITE_X, SPRITE_Y;
  logic [7:0] PIXEL_DOUT;
  logic [8:0] PIXEL_X, PIXEL_Y;

  always #10 CLOCK_50 = ~CLOCK_50;

  sprite_blitter dut (
    .CLOCK_50   (CLOCK_50),
    .RESET_N    (RESET_N),
    .START      (START),
    .CFG_WE     (CFG_WE),
    .CFG_SLOT   (CFG_SLOT),
    .CFG_X      (CFG_X),
    .CFG_Y      (CFG_Y),
    .CFG_ID     (CFG_ID),
    .CFG_EN     (CFG_EN),
    .CFG_FLIPX  (CFG_FLIPX),
    .CFG_FLIPY  (CFG_FLIPY),
    .PIXEL_DIN  (PIXEL_DIN),
    .RE         (RE),
    .SPRITE_ID  (SPRITE_ID),
    .SPRITE_X   (SPRITE_X),
    .SPRITE_Y   (SPRITE_Y),
    .WE         (WE),
    .PIXEL_DOUT (PIXEL_DOUT),
    .PIXEL_X    (PIXEL_X),
    .PIXEL_Y    (PIXEL_Y),
    .BUSY       (BUSY),
    .SPR_DONE   (SPR_DONE)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string nm, input longint act,
                       input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Shadow of the descriptor table as the bench wrote it.
  int sh_x[N], sh_y[N], sh_id[N];
  bit sh_en[N], sh_fx[N], sh_fy[N];

  int mode = 0;
  int seed = 0;

  function automatic logic [7:0] rom(int id, int sx, int sy);
    case (mode)
      0: return 8'h11;
      1: return (sx % 2 == 0) ? KEYV : 8'h11;
      2: return 8'((sx * 8) + (sy % 8));
      default: return 8'(sx * 7 + sy * 13 + id * 53 + seed);
    endcase
  endfunction

  typedef struct {
    int x;
    int y;
    int d;
  } wr_t;

  wr_t expq[$];
  wr_t e;

  // Expected writes: every enabled slot, row-major, keyed/clipped.
  task automatic build_model();
    expq.delete();
    for (int s = 0; s < N; s++) begin
      if (sh_en[s]) begin
        for (int r = 0; r < S; r++) begin
          for (int c = 0; c < S; c++) begin
            wr_t w;
            int sx, sy;
            sx = sh_fx[s] ? S - 1 - c : c;
            sy = sh_fy[s] ? S - 1 - r : r;
            w.d = rom(sh_id[s], sx, sy);
            w.x = sh_x[s] + c;
            w.y = sh_y[s] + r;
            if (w.d != KEYV && w.x < 320 && w.y < 240)
              expq.push_back(w);
          end
        end
      end
    end
  endtask

  // ROM: answers each read LAT cycles later.
  logic [7:0] h_d[64];
  int cyc = 0;
  initial begin
    forever begin
      @(negedge CLOCK_50);
      h_d[cyc % 64] = RE ? rom(int'(SPRITE_ID), int'(SPRITE_X),
                               int'(SPRITE_Y))
                         : 8'($urandom);
      if (cyc >= LAT) PIXEL_DIN = h_d[(cyc - LAT) % 64];
      cyc++;
    end
  end

  // Write-port compare plus a few statistics for directed checks.
  int wcnt = 0, oddbad = 0, mx = 0, my = 0;
  int fx = -1, fy = -1, fd = -1, lx = -1, ly = -1, d31 = -1;
  initial begin
    forever begin
      @(negedge CLOCK_50);
      if (RESET_N) begin
        if (WE) begin
          if (expq.size() == 0) begin
            check("spurious_we", 1, 0);
          end else begin
            e = expq.pop_front();
            check("wr_x", PIXEL_X, e.x);
            check("wr_y", PIXEL_Y, e.y);
            check("wr_data", PIXEL_DOUT, e.d);
          end
          if (wcnt == 0) begin
            fx = int'(PIXEL_X);
            fy = int'(PIXEL_Y);
            fd = int'(PIXEL_DOUT);
          end
          lx = int'(PIXEL_X);
          ly = int'(PIXEL_Y);
          if (int'(PIXEL_X) > mx) mx = int'(PIXEL_X);
          if (int'(PIXEL_Y) > my) my = int'(PIXEL_Y);
          if (PIXEL_X == 9'd31 && PIXEL_Y == 9'd0)
            d31 = int'(PIXEL_DOUT);
          if (((int'(PIXEL_X) - 10) % 2) == 0) oddbad++;
          wcnt++;
        end else begin
          check("dout_idle", PIXEL_DOUT, 0);
        end
      end
    end
  end

  task automatic cfg(input int s, input int x, input int y,
                     input int id, input bit en, input bit fxl,
                     input bit fyl);
    @(negedge CLOCK_50);
    CFG_SLOT = 2'(s);
    CFG_X = 9'(x);
    CFG_Y = 9'(y);
    CFG_ID = 2'(id);
    CFG_EN = en;
    CFG_FLIPX = fxl;
    CFG_FLIPY = fyl;
    CFG_WE = 1'b1;
    @(negedge CLOCK_50);
    CFG_WE = 1'b0;
    sh_x[s] = x;
    sh_y[s] = y;
    sh_id[s] = id;
    sh_en[s] = en;
    sh_fx[s] = fxl;
    sh_fy[s] = fyl;
  endtask

  task automatic clr_shadow();
    for (int s = 0; s < N; s++) begin
      sh_x[s] = 0;
      sh_y[s] = 0;
      sh_id[s] = 0;
      sh_en[s] = 0;
      sh_fx[s] = 0;
      sh_fy[s] = 0;
    end
  endtask

  task automatic reset_stats();
    wcnt = 0;
    oddbad = 0;
    mx = 0;
    my = 0;
    fx = -1;
    fy = -1;
    fd = -1;
    d31 = -1;
  endtask

  // Optional descriptor write issued in the START cycle.
  bit pend = 0;
  int p_s, p_x, p_y, p_id;
  bit p_en, p_fx, p_fy;
  int last_busy = 0;

  task automatic run(input string nm);
    int en_n, cnt, i;
    bit done;
    if (pend) begin
      sh_x[p_s] = p_x;
      sh_y[p_s] = p_y;
      sh_id[p_s] = p_id;
      sh_en[p_s] = p_en;
      sh_fx[p_s] = p_fx;
      sh_fy[p_s] = p_fy;
    end
    en_n = 0;
    for (int s = 0; s < N; s++) if (sh_en[s]) en_n++;
    build_model();
    reset_stats();
    @(negedge CLOCK_50);
    START = 1'b1;
    if (pend) begin
      CFG_SLOT = 2'(p_s);
      CFG_X = 9'(p_x);
      CFG_Y = 9'(p_y);
      CFG_ID = 2'(p_id);
      CFG_EN = p_en;
      CFG_FLIPX = p_fx;
      CFG_FLIPY = p_fy;
      CFG_WE = 1'b1;
    end
    @(negedge CLOCK_50);
    START = 1'b0;
    CFG_WE = 1'b0;
    pend = 0;
    cnt = 0;
    done = 0;
    i = 0;
    while (!done && i < 20000) begin
      if (SPR_DONE) begin
        done = 1;
      end else begin
        if (BUSY) cnt++;
        @(negedge CLOCK_50);
        i++;
      end
    end
    check({nm, "_done"}, done, 1);
    check({nm, "_busy_cycles"}, cnt, N + en_n * S * S + LAT + 1);
    check({nm, "_busy_at_done"}, BUSY, 0);
    check({nm, "_writes_left"}, expq.size(), 0);
    last_busy = cnt;
    @(negedge CLOCK_50);
    check({nm, "_done_pulse"}, SPR_DONE, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    clr_shadow();
    #5;
    check("rst_we", WE, 0);
    check("rst_re", RE, 0);
    check("rst_busy", BUSY, 0);
    check("rst_done", SPR_DONE, 0);
    check("rst_px", PIXEL_X, 0);
    check("rst_sx", SPRITE_X, 0);
    @(negedge CLOCK_50);
    @(negedge CLOCK_50);
    RESET_N = 1'b1;

    // Plain sprite, all opaque.
    cfg(0, 10, 20, 1, 1, 0, 0);
    mode = 0;
    run("s1");
    check("s1_count", wcnt, 1024);
    check("s1_first_x", fx, 10);
    check("s1_first_y", fy, 20);
    check("s1_last_x", lx, 41);
    check("s1_last_y", ly, 51);
    check("s1_busy_lit", last_busy, 1030);

    // Even ROM columns are transparent.
    mode = 1;
    run("s2");
    check("s2_count", wcnt, 512);
    check("s2_even_written", oddbad, 0);

    // Clipped against the bottom-right corner.
    cfg(0, 300, 230, 1, 1, 0, 0);
    mode = 0;
    run("s3");
    check("s3_count", wcnt, 200);
    check("s3_max_x", mx, 319);
    check("s3_max_y", my, 239);

    // Both flips.
    cfg(0, 0, 0, 2, 1, 1, 1);
    mode = 2;
    run("s4");
    check("s4_count", wcnt, 1020);
    check("s4_first_x", fx, 0);
    check("s4_first_y", fy, 0);
    check("s4_first_data", fd, 8'hFF);
    check("s4_x31_data", d31, 8'h07);

    // Two slots with gaps.
    cfg(0, 50, 60, 1, 1, 0, 0);
    cfg(2, 100, 100, 3, 1, 0, 0);
    mode = 0;
    run("s5");
    check("s5_count", wcnt, 2048);
    check("s5_first_x", fx, 50);
    check("s5_busy_lit", last_busy, 2054);

    // Reset part-way through a draw.
    cfg(0, 10, 20, 1, 1, 0, 0);
    build_model();
    reset_stats();
    @(negedge CLOCK_50);
    START = 1'b1;
    @(negedge CLOCK_50);
    START = 1'b0;
    for (int i = 0; i < 3000 && wcnt < 100; i++)
      @(negedge CLOCK_50);
    check("s6_reached_100", wcnt >= 100, 1);
    #2;
    RESET_N = 1'b0;
    #1;
    check("s6_rst_we", WE, 0);
    check("s6_rst_re", RE, 0);
    check("s6_rst_done", SPR_DONE, 0);
    check("s6_rst_busy", BUSY, 0);
    check("s6_rst_dout", PIXEL_DOUT, 0);
    @(negedge CLOCK_50);
    @(negedge CLOCK_50);
    RESET_N = 1'b1;
    clr_shadow();
    expq.delete();

    // Cleared table: scan only, no writes.
    run("empty");
    check("empty_count", wcnt, 0);
    check("empty_busy_lit", last_busy, 6);

    // Descriptor write and START while busy are ignored.
    cfg(0, 10, 20, 1, 1, 0, 0);
    fork
      run("busy");
      begin
        repeat (50) @(negedge CLOCK_50);
        CFG_SLOT = 2'd0;
        CFG_X = 9'd200;
        CFG_Y = 9'd5;
        CFG_ID = 2'd3;
        CFG_EN = 1'b1;
        CFG_WE = 1'b1;
        START = 1'b1;
        @(negedge CLOCK_50);
        CFG_WE = 1'b0;
        START = 1'b0;
      end
    join
    check("busy_count", wcnt, 1024);
    repeat (3) @(negedge CLOCK_50);
    check("busy_no_restart", BUSY, 0);
    run("after");
    check("after_first_x", fx, 10);
    check("after_first_y", fy, 20);

    // Random tables; last write lands in the START cycle.
    for (int k = 0; k < 3; k++) begin
      mode = 3;
      seed = int'($urandom_range(255));
      for (int s = 0; s < N - 1; s++)
        cfg(s, int'($urandom_range(511)), int'($urandom_range(511)),
            int'($urandom_range(3)), 1'($urandom), 1'($urandom),
            1'($urandom));
      pend = 1;
      p_s = N - 1;
      p_x = int'($urandom_range(330));
      p_y = int'($urandom_range(250));
      p_id = int'($urandom_range(3));
      p_en = 1'b1;
      p_fx = 1'($urandom);
      p_fy = 1'($urandom);
      run($sformatf("rnd%0d", k));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
